// File: rtl/osd_mam_burst_splitter.sv
// Splits one MAM access into bursts of at most MAX_BEATS words that never cross a
// BOUNDARY-byte line. Data streams through combinationally during each sub-burst.
module osd_mam_burst_splitter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BEATS  = 16,
    parameter int BOUNDARY   = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    up_req_valid,
    output logic                    up_req_ready,
    input  logic                    up_req_rw,
    input  logic [ADDR_WIDTH-1:0]   up_req_addr,
    input  logic                    up_req_burst,
    input  logic [13:0]             up_req_beats,
    input  logic                    up_write_valid,
    output logic                    up_write_ready,
    input  logic [DATA_WIDTH-1:0]   up_write_data,
    input  logic [DATA_WIDTH/8-1:0] up_write_strb,
    output logic                    up_read_valid,
    input  logic                    up_read_ready,
    output logic [DATA_WIDTH-1:0]   up_read_data,
    output logic                    dn_req_valid,
    input  logic                    dn_req_ready,
    output logic                    dn_req_rw,
    output logic [ADDR_WIDTH-1:0]   dn_req_addr,
    output logic                    dn_req_burst,
    output logic [13:0]             dn_req_beats,
    output logic                    dn_write_valid,
    input  logic                    dn_write_ready,
    output logic [DATA_WIDTH-1:0]   dn_write_data,
    output logic [DATA_WIDTH/8-1:0] dn_write_strb,
    input  logic                    dn_read_valid,
    output logic                    dn_read_ready,
    input  logic [DATA_WIDTH-1:0]   dn_read_data
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int BW  = $clog2(BOUNDARY);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [13:0]           remaining;
    logic [13:0]           chunk_cnt;
    logic                  rw;
    logic                  burst;
    logic [13:0]           chunk;
    logic [31:0]           room;
    logic                  xfer;
    logic                  hs;
    logic                  req_empty;

    // Words left before the next boundary line.
    assign room = (32'(BOUNDARY) - 32'(cur_addr[BW-1:0])) / 32'(BPW);

    always_comb begin
        chunk = remaining;
        if (chunk > 14'(MAX_BEATS)) chunk = 14'(MAX_BEATS);
        if (32'(chunk) > room)      chunk = room[13:0];
        if (!burst)                 chunk = 14'd1;
    end

    assign xfer      = (state == XFER);
    assign req_empty = up_req_burst && (up_req_beats == 14'd0);

    assign up_req_ready   = (state == IDLE);
    assign dn_req_valid   = (state == ISSUE);
    assign dn_req_rw      = rw;
    assign dn_req_burst   = burst;
    assign dn_req_addr    = cur_addr;
    assign dn_req_beats   = (state == ISSUE) ? chunk : 14'd0;

    // Write valid must stay low outside XFER: the adapter samples write data while idle.
    assign dn_write_valid = xfer && rw && up_write_valid;
    assign up_write_ready = xfer && rw && dn_write_ready;
    assign dn_write_data  = up_write_data;
    assign dn_write_strb  = up_write_strb;
    assign up_read_valid  = xfer && !rw && dn_read_valid;
    assign dn_read_ready  = xfer && !rw && up_read_ready;
    assign up_read_data   = dn_read_data;

    assign hs = rw ? (dn_write_valid && dn_write_ready) : (up_read_valid && up_read_ready);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (up_req_valid && !req_empty) state_nxt = ISSUE;
            ISSUE: if (dn_req_ready) state_nxt = XFER;
            XFER:  if (hs && chunk_cnt == 14'd1)
                       state_nxt = (remaining != 14'd0) ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            chunk_cnt <= '0;
            rw        <= 1'b0;
            burst     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (up_req_valid) begin
                    rw        <= up_req_rw;
                    burst     <= up_req_burst;
                    cur_addr  <= up_req_addr;
                    remaining <= up_req_burst ? up_req_beats : 14'd1;
                end
                ISSUE: if (dn_req_ready) begin
                    chunk_cnt <= chunk;
                    remaining <= remaining - chunk;
                    cur_addr  <= cur_addr + ADDR_WIDTH'(32'(chunk) * 32'(BPW));
                end
                XFER: if (hs) chunk_cnt <= chunk_cnt - 14'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/osd_mam_burst_splitter.md
Name: osd_mam_burst_splitter

Overview:
- Sits between the MAM request/data engine and the Wishbone bus adapter.
- Splits an incoming MAM access into a sequence of bus-legal bursts.
- Each burst is at most MAX_BEATS words and never crosses a BOUNDARY-byte address boundary.
- Read and write data stream through unchanged; the next sub-burst is issued only after the previous one has fully transferred its data.

Parameters:
DATA_WIDTH, 16, data word width in bits; multiple of 16
ADDR_WIDTH, 32, byte address width
MAX_BEATS, 16, maximum beats per downstream burst; power of 2, 1..8192
BOUNDARY, 1024, burst address boundary in bytes; power of 2, >= MAX_BEATS*DATA_WIDTH/8

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
up_req_valid  in  1  upstream request valid
up_req_ready  out  1  upstream request accept
up_req_rw  in  1  0 read, 1 write
up_req_addr  in  ADDR_WIDTH  base byte address, word-aligned
up_req_burst  in  1  0 single beat, 1 incremental burst
up_req_beats  in  14  burst length in words
up_write_valid / up_write_ready  in / out  1  upstream write data handshake
up_write_data  in  DATA_WIDTH  write data
up_write_strb  in  DATA_WIDTH/8  byte strobe
up_read_valid / up_read_ready  out / in  1  upstream read data handshake
up_read_data  out  DATA_WIDTH  read data
dn_req_valid / dn_req_ready  out / in  1  downstream request handshake
dn_req_rw  out  1  copy of latched rw
dn_req_addr  out  ADDR_WIDTH  sub-burst base address
dn_req_burst  out  1  copy of latched burst flag
dn_req_beats  out  14  sub-burst length
dn_write_valid / dn_write_ready  out / in  1  downstream write handshake
dn_write_data  out  DATA_WIDTH  write data
dn_write_strb  out  DATA_WIDTH/8  byte strobe
dn_read_valid / dn_read_ready  in / out  1  downstream read handshake
dn_read_data  in  DATA_WIDTH  read data

Behaviour:
- Word size BPW = DATA_WIDTH/8 bytes.
- Internal registers:
  - cur_addr (ADDR_WIDTH)
  - remaining (14 bit)
  - chunk_cnt (14 bit)
  - rw, burst
- States: IDLE, ISSUE, XFER.

IDLE:
- up_req_ready = 1.
- On up_req_valid, latch rw, burst and addr; go to ISSUE.
- If burst=0, latch remaining = 1.
- If burst=1 and beats=0, the request is consumed with no downstream request; stay in IDLE.

ISSUE:
- dn_req_valid = 1 (registered; asserted the cycle after upstream accept).
- chunk = 1 when burst=0; otherwise chunk = min(remaining, MAX_BEATS, (BOUNDARY - cur_addr mod BOUNDARY)/BPW).
- Held stable while dn_req_valid is high.
- On dn_req_ready:
  - chunk_cnt <= chunk
  - remaining <= remaining - chunk
  - cur_addr <= cur_addr + chunk*BPW (wraps modulo 2^ADDR_WIDTH)
  - go to XFER

XFER:
- Data paths are combinational pass-through:
  - write: up_write_* to dn_write_*, dn_write_ready to up_write_ready
  - read: dn_read_* to up_read_*, up_read_ready to dn_read_ready
- Each downstream data handshake (write or read) decrements chunk_cnt.
- When the handshake takes chunk_cnt from 1 to 0: go to ISSUE if remaining != 0, else IDLE.

Outside XFER:
- dn_write_valid, up_write_ready, up_read_valid and dn_read_ready are all 0.
- Gating dn_write_valid matters because the downstream adapter samples write data during its idle request cycle.

Simultaneous events:
- A new upstream request is never accepted before the previous one completes; up_req_ready is 1 only in IDLE.

Reset:
- Asynchronous; any state goes to IDLE.
- All handshake outputs 0 except up_req_ready = 1.
- dn_req_addr, dn_req_beats, and all registers clear to 0.
- Reset mid-transfer abandons the access; no further beats are forwarded.
- Data outputs not listed above are combinational copies of their sources.

Latency:
- Upstream accept to dn_req_valid: 1 cycle.
- Last data beat of a chunk to next dn_req_valid: 1 cycle.

Test Plan:
- Single write, burst=0, addr 0x100, beats 7 -> one dn request: burst=0, beats=1, addr 0x100; exactly one write beat forwarded; IDLE afterwards.
- Burst read, 40 beats at 0x0 (DATA_WIDTH 16, MAX_BEATS 16) -> dn requests 16@0x000, 16@0x020, 8@0x040; 40 read beats delivered in order; up_req_ready reasserts the cycle after the 40th beat.
- Boundary crossing: write burst, 10 beats at 0x3F8 (BOUNDARY 1024) -> dn requests 4@0x3F8 then 6@0x400; strobes and data pass unchanged.
- Burst with beats=0 -> accepted in one cycle; dn_req_valid stays 0; up_req_ready remains 1.
- Backpressure: 32-beat write with up_write_valid toggled every other cycle and dn_req_ready delayed 3 cycles -> second dn_req_valid (addr +0x20) rises exactly one cycle after the 16th beat handshake; dn_write_valid is 0 during ISSUE.
- Reset asserted mid-second chunk -> dn_req_valid, dn_write_valid and up_read_valid drop in the same cycle (async); after release, up_req_ready=1 and a new 2-beat read completes normally.
